// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared constants, bus types and the stage-update decode used by
// the EX/MEM pipeline register.
//   RstEnable/WriteDisable/ZeroWord/NOPRegAddr : reset/clear values
//   Stop/NoStop                                : stall-bit encodings
//   reg_addr_bus_t/reg_bus_t/double_reg_bus_t  : [4:0]/[31:0]/[63:0] buses
//   stage_action()                             : per-edge update priority
package ex_mem_pkg;

  localparam logic        RstEnable    = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr   = 5'b00000;
  localparam logic        Stop         = 1'b1;
  localparam logic        NoStop       = 1'b0;

  // Stall vector positions: pc, if, id, ex, mem, wb.
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

  typedef logic [4:0]  reg_addr_bus_t;
  typedef logic [31:0] reg_bus_t;
  typedef logic [63:0] double_reg_bus_t;

  typedef enum logic [1:0] {
    ACT_CLEAR  = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2,
    ACT_PASS   = 2'd3
  } stage_act_e;

  // Priority: reset, flush, bubble, hold, pass. EX running while MEM stalls
  // cannot happen in a consistent pipeline; it falls through to pass.
  function automatic stage_act_e stage_action(input logic rst,
                                              input logic flush,
                                              input logic [5:0] stall);
    stage_act_e act;
    if (rst == RstEnable) begin
      act = ACT_CLEAR;
    end else if (flush == 1'b1) begin
      act = ACT_CLEAR;
    end else if (stall[STALL_EX] == Stop && stall[STALL_MEM] == NoStop) begin
      act = ACT_BUBBLE;
    end else if (stall[STALL_EX] == Stop) begin
      act = ACT_HOLD;
    end else begin
      act = ACT_PASS;
    end
    return act;
  endfunction

endpackage

// File: rtl/ex_mem_if.sv
// ex_mem_if: EX -> MEM pipeline bus.
//   ex_*      : result, destination and HI/LO write from EX
//   hilo_i/cnt_i : madd/msub partial product and step count from EX
//   mem_*     : registered copy presented to MEM
//   hilo_o/cnt_o : registered partial product/count fed back to EX
// master = EX side (drives ex_*), slave = the pipeline register.
interface ex_mem_if;
  import ex_mem_pkg::*;

  reg_addr_bus_t   ex_wd;
  logic            ex_wreg;
  reg_bus_t        ex_wdata;
  logic            ex_whilo;
  reg_bus_t        ex_hi;
  reg_bus_t        ex_lo;
  double_reg_bus_t hilo_i;
  logic [1:0]      cnt_i;

  reg_addr_bus_t   mem_wd;
  logic            mem_wreg;
  reg_bus_t        mem_wdata;
  logic            mem_whilo;
  reg_bus_t        mem_hi;
  reg_bus_t        mem_lo;
  double_reg_bus_t hilo_o;
  logic [1:0]      cnt_o;

  modport master (
    output ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, hilo_i, cnt_i,
    input  mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_o, cnt_o
  );

  modport slave (
    input  ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, hilo_i, cnt_i,
    output mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_o, cnt_o
  );

endinterface

// File: rtl/ex_mem.sv
// ex_mem: EX/MEM pipeline register, one cycle latency, all outputs registered.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   stall : [5:0] pc,if,id,ex,mem,wb; only bits 3 (EX) and 4 (MEM) matter
//   flush : exception flush, clears the stage like reset
//   bus   : ex_mem_if slave (ex_* in, mem_*/hilo_o/cnt_o out)
// A bubble inserts a NOP toward MEM but keeps the madd/msub partial product
// and step count alive so the stalled EX stage can continue the operation.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic         flush,
  ex_mem_if.slave      bus
);

  reg_addr_bus_t   mem_wd_r;
  logic            mem_wreg_r;
  reg_bus_t        mem_wdata_r;
  logic            mem_whilo_r;
  reg_bus_t        mem_hi_r;
  reg_bus_t        mem_lo_r;
  double_reg_bus_t hilo_r;
  logic [1:0]      cnt_r;

  // Stage register: clear, bubble, hold or pass, decided once per edge.
  always_ff @(posedge clk) begin
    case (stage_action(rst, flush, stall))
      ACT_CLEAR: begin
        mem_wd_r    <= NOPRegAddr;
        mem_wreg_r  <= WriteDisable;
        mem_wdata_r <= ZeroWord;
        mem_whilo_r <= WriteDisable;
        mem_hi_r    <= ZeroWord;
        mem_lo_r    <= ZeroWord;
        hilo_r      <= 64'h0;
        cnt_r       <= 2'b00;
      end
      ACT_BUBBLE: begin
        mem_wd_r    <= NOPRegAddr;
        mem_wreg_r  <= WriteDisable;
        mem_wdata_r <= ZeroWord;
        mem_whilo_r <= WriteDisable;
        mem_hi_r    <= ZeroWord;
        mem_lo_r    <= ZeroWord;
        hilo_r      <= bus.hilo_i;
        cnt_r       <= bus.cnt_i;
      end
      ACT_HOLD: begin
        mem_wd_r    <= mem_wd_r;
        mem_wreg_r  <= mem_wreg_r;
        mem_wdata_r <= mem_wdata_r;
        mem_whilo_r <= mem_whilo_r;
        mem_hi_r    <= mem_hi_r;
        mem_lo_r    <= mem_lo_r;
        hilo_r      <= hilo_r;
        cnt_r       <= cnt_r;
      end
      default: begin
        // Pass: a completed multi-cycle op leaves no partial state behind.
        mem_wd_r    <= bus.ex_wd;
        mem_wreg_r  <= bus.ex_wreg;
        mem_wdata_r <= bus.ex_wdata;
        mem_whilo_r <= bus.ex_whilo;
        mem_hi_r    <= bus.ex_hi;
        mem_lo_r    <= bus.ex_lo;
        hilo_r      <= 64'h0;
        cnt_r       <= 2'b00;
      end
    endcase
  end

  assign bus.mem_wd    = mem_wd_r;
  assign bus.mem_wreg  = mem_wreg_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.mem_whilo = mem_whilo_r;
  assign bus.mem_hi    = mem_hi_r;
  assign bus.mem_lo    = mem_lo_r;
  assign bus.hilo_o    = hilo_r;
  assign bus.cnt_o     = cnt_r;

endmodule

// File: tb/tb_ex_mem.sv
// tb_ex_mem: directed scenarios plus randomized traffic for ex_mem, checked
// against a behavioural model of the stage written from its update rules.
module tb_ex_mem;

  logic       clk;
  logic       rst;
  logic [5:0] stall;
  logic       flush;
  int         n_checks;
  int         n_errors;

  ex_mem_if bus ();

  ex_mem dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } view_t;

  view_t model;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: what the stage should hold after one edge with these inputs.
  function automatic view_t predict(input view_t cur);
    view_t nx;
    logic  ex_stalled;
    logic  mem_stalled;
    nx          = cur;
    ex_stalled  = stall[3];
    mem_stalled = stall[4];
    if (rst || flush) begin
      nx = '{5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 64'd0, 2'd0};
    end else if (ex_stalled && !mem_stalled) begin
      nx = '{5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, bus.hilo_i, bus.cnt_i};
    end else if (ex_stalled) begin
      nx = cur;
    end else begin
      nx = '{bus.ex_wd, bus.ex_wreg, bus.ex_wdata, bus.ex_whilo,
             bus.ex_hi, bus.ex_lo, 64'd0, 2'd0};
    end
    return nx;
  endfunction

  task automatic compare_all(input string tag);
    check_val({tag, ".wd"},    {59'd0, bus.mem_wd},    {59'd0, model.wd});
    check_val({tag, ".wreg"},  {63'd0, bus.mem_wreg},  {63'd0, model.wreg});
    check_val({tag, ".wdata"}, {32'd0, bus.mem_wdata}, {32'd0, model.wdata});
    check_val({tag, ".whilo"}, {63'd0, bus.mem_whilo}, {63'd0, model.whilo});
    check_val({tag, ".hi"},    {32'd0, bus.mem_hi},    {32'd0, model.hi});
    check_val({tag, ".lo"},    {32'd0, bus.mem_lo},    {32'd0, model.lo});
    check_val({tag, ".hilo"},  bus.hilo_o,             model.hilo);
    check_val({tag, ".cnt"},   {62'd0, bus.cnt_o},     {62'd0, model.cnt});
  endtask

  // One clock: predict, take the edge, settle, compare everything.
  task automatic tick(input string tag);
    view_t nx;
    logic  illegal;
    illegal = (stall[3] == 1'b0) && (stall[4] == 1'b1);
    check_val({tag, ".stall_legal"}, {63'd0, illegal}, 64'd0);
    nx = predict(model);
    @(posedge clk);
    #1;
    model = nx;
    compare_all(tag);
  endtask

  task automatic drive_ex(input logic [4:0] wd, input logic wreg,
                          input logic [31:0] wdata, input logic whilo,
                          input logic [31:0] hi, input logic [31:0] lo,
                          input logic [63:0] hilo, input logic [1:0] cnt);
    bus.ex_wd    = wd;
    bus.ex_wreg  = wreg;
    bus.ex_wdata = wdata;
    bus.ex_whilo = whilo;
    bus.ex_hi    = hi;
    bus.ex_lo    = lo;
    bus.hilo_i   = hilo;
    bus.cnt_i    = cnt;
  endtask

  task automatic drive_random();
    drive_ex(5'($urandom), 1'($urandom), 32'($urandom), 1'($urandom),
             32'($urandom), 32'($urandom), {32'($urandom), 32'($urandom)},
             2'($urandom_range(0, 2)));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model    = '{5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 64'd0, 2'd0};
    rst      = 1'b1;
    flush    = 1'b0;
    stall    = 6'b000000;
    drive_ex(5'd7, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h1, 32'h2, 64'h3, 2'd2);

    // Reset held for two edges.
    @(posedge clk);
    tick("reset");
    check_val("reset.cnt_const", {62'd0, bus.cnt_o}, 64'd0);
    check_val("reset.wd_const", {59'd0, bus.mem_wd}, 64'd0);

    // Plain pass.
    rst = 1'b0;
    drive_ex(5'd3, 1'b1, 32'h1234_5678, 1'b0, 32'd0, 32'd0, 64'h9, 2'd2);
    tick("pass");
    check_val("pass.wdata_const", {32'd0, bus.mem_wdata}, 64'h1234_5678);
    check_val("pass.wd_const", {59'd0, bus.mem_wd}, 64'd3);

    // Bubble: NOP to MEM, partial product and count captured.
    stall = 6'b001111;
    drive_ex(5'd9, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h5, 32'h6,
             64'h0000_0001_0000_0002, 2'd1);
    tick("bubble");
    check_val("bubble.hilo_const", bus.hilo_o, 64'h0000_0001_0000_0002);
    check_val("bubble.cnt_const", {62'd0, bus.cnt_o}, 64'd1);
    check_val("bubble.wdata_const", {32'd0, bus.mem_wdata}, 64'd0);

    // Hold for three cycles while inputs keep changing.
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      drive_random();
      tick("hold");
    end
    check_val("hold.cnt_const", {62'd0, bus.cnt_o}, 64'd1);

    // HI/LO pass.
    stall = 6'b000000;
    drive_ex(5'd1, 1'b0, 32'd0, 1'b1, 32'hAAAA_0001, 32'h5555_0002, 64'd0, 2'd0);
    tick("hilo");
    check_val("hilo.hi_const", {32'd0, bus.mem_hi}, 64'hAAAA_0001);
    check_val("hilo.lo_const", {32'd0, bus.mem_lo}, 64'h5555_0002);

    // Flush while holding mid-madd.
    stall = 6'b001111;
    drive_ex(5'd4, 1'b1, 32'h1, 1'b1, 32'h2, 32'h3, 64'h77, 2'd1);
    tick("pre_flush");
    stall = 6'b011111;
    flush = 1'b1;
    drive_random();
    tick("flush");
    check_val("flush.cnt_const", {62'd0, bus.cnt_o}, 64'd0);
    check_val("flush.wreg_const", {63'd0, bus.mem_wreg}, 64'd0);
    flush = 1'b0;

    // Reset mid-stream, then pass resumes.
    stall = 6'b000000;
    drive_random();
    tick("stream");
    rst = 1'b1;
    drive_random();
    tick("mid_reset");
    check_val("mid_reset.hilo_const", bus.hilo_o, 64'd0);
    rst = 1'b0;
    drive_ex(5'd30, 1'b1, 32'hCAFE_F00D, 1'b0, 32'd0, 32'd0, 64'd0, 2'd0);
    tick("resume");
    check_val("resume.wdata_const", {32'd0, bus.mem_wdata}, 64'hCAFE_F00D);

    // Randomized traffic over legal stall combinations; ignored bits random.
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel   = int'($urandom_range(0, 9));
      stall = 6'($urandom) & 6'b100111;
      if (sel < 5) begin
        stall[4:3] = 2'b00;
      end else if (sel < 7) begin
        stall[4:3] = 2'b01;
      end else begin
        stall[4:3] = 2'b11;
      end
      flush = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 29) == 0);
      drive_random();
      tick("random");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 Reset is synchronous and active-high; one clock.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous reset, active-high (`RstEnable`).
REQ-004 stall  in  6  pipeline stall vector `[5:0]`: pc, if, id, ex, mem, wb; bit 3 = EX stalled, bit 4 = MEM stalled.
REQ-005 flush  in  1  exception flush; clears the stage.
REQ-006 ex_wd / ex_wreg / ex_wdata  in  5/1/32  destination address, write-enable and result from EX.
REQ-007 ex_whilo / ex_hi / ex_lo  in  1/32/32  HI/LO write-enable and values from EX.
REQ-008 hilo_i / cnt_i  in  64/2  madd/msub partial product and cycle count from EX.
REQ-009 mem_wd / mem_wreg / mem_wdata  out  5/1/32  registered outputs to MEM.
REQ-010 mem_whilo / mem_hi / mem_lo  out  1/32/32  registered HI/LO outputs to MEM.
REQ-011 hilo_o / cnt_o  out  64/2  registered partial product and count, fed back to EX.

Function
REQ-012 All outputs are registers updated only on the rising edge of clk; latency EX->MEM is exactly 1 cycle; there is no combinational input-to-output path.
REQ-013 Update priority per edge: rst, then flush, then bubble, then hold, then pass.
REQ-014 Bubble condition:
- stall[3]=1 and stall[4]=0.
- mem_wd <= `NOPRegAddr`; mem_wreg/mem_whilo <= 0; mem_wdata/mem_hi/mem_lo <= 0.
- hilo_o <= hilo_i; cnt_o <= cnt_i.
REQ-015 Hold condition:
- stall[3]=1 and stall[4]=1.
- Every output register keeps its value, including hilo_o and cnt_o.
REQ-016 Pass condition:
- stall[3]=0.
- All mem_* outputs <= the corresponding ex_* inputs.
- hilo_o <= 0; cnt_o <= 0.
REQ-017 stall[3]=0 with stall[4]=1 is illegal; the block treats it as pass, and the bench asserts it never occurs.
REQ-018 Flush: same clearing as reset, including hilo_o=0 and cnt_o=0; this aborts an in-flight madd/msub.
REQ-019 cnt_o never increments locally; it only captures cnt_i, with values 0..2 and no wrap logic.
REQ-020 Simultaneous flush and stall: flush wins; outputs are cleared regardless of stall.
REQ-021 stall bits 0-2 and 5 are ignored.

Reset
REQ-022 On rst=1 at an edge, outputs are:
- mem_wd=`NOPRegAddr` (5'b0), mem_wreg=`WriteDisable`, mem_wdata=`ZeroWord`.
- mem_whilo=0, mem_hi=0, mem_lo=0, hilo_o=64'h0, cnt_o=2'b00.
REQ-023 Reset asserted mid-madd (cnt_o=1) clears the partial state on that edge; the next cycle sees cnt_o=0.
REQ-024 Outputs are undefined before the first reset edge; the bench starts with rst held high for ≥2 cycles.

Structure
REQ-025 Shared defines file holds:
- `RstEnable`, `WriteDisable`, `ZeroWord`, `NOPRegAddr`.
- `RegAddrBus` [4:0], `RegBus` [31:0], `DoubleRegBus` [63:0].
- New: `Stop`/`NoStop` for stall bits.
REQ-026 No sub-module; a single always block on posedge clk.
REQ-027 The instantiating top wires mem_* to mem's *_i ports and hilo_o/cnt_o to ex's hilo_temp/cnt inputs.

Verification
REQ-028 Inputs are ex_wd=5'd3, ex_wreg=1, ex_wdata=32'h1234_5678, stall=0; next cycle mem_wd=3, mem_wreg=1, mem_wdata=32'h1234_5678, cnt_o=0.
REQ-029 Starting from REQ-028 state, stall=6'b001111 with new inputs ex_wdata=32'hDEAD_BEEF; mem outputs are bubbled to 0/`NOPRegAddr`, hilo_o=hilo_i=64'h0000_0001_0000_0002, cnt_o=cnt_i=1.
REQ-030 stall=6'b011111 for 3 cycles with changing inputs; all outputs are unchanged from the prior cycle for each cycle.
REQ-031 ex_whilo=1, ex_hi=32'hAAAA_0001, ex_lo=32'h5555_0002; next cycle mem_whilo=1, mem_hi=32'hAAAA_0001, mem_lo=32'h5555_0002.
REQ-032 Under flush=1 with stall=6'b011111 and cnt_o=1, the next cycle has all outputs zero, mem_wreg=0 and cnt_o=0.
REQ-033 rst=1 for one cycle mid-stream; outputs match REQ-022 and pass behaviour resumes on the cycle after rst drops.
